// File: rtl/ara_inval_buffer.sv
// ara_inval_buffer
// Buffers cache-line invalidations from the coprocessor-side AXI filter
// and delivers them to CVA6. Requests to a line that is already queued are
// coalesced instead of pushed, and a saturating counter tracks how often
// that happens.
module ara_inval_buffer #(
    parameter int unsigned Depth     = 4,
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned LineBytes = 16,
    parameter int unsigned CntWidth  = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 en_i,
    input  logic                 clr_cnt_i,
    input  logic [AddrWidth-1:0] inval_addr_i,
    input  logic                 inval_valid_i,
    output logic                 inval_ready_o,
    output logic [AddrWidth-1:0] inval_addr_o,
    output logic                 inval_valid_o,
    input  logic                 inval_ready_i,
    output logic                 busy_o,
    output logic [CntWidth-1:0]  coalesce_cnt_o
);

    localparam int unsigned IdxW    = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned PtrW    = IdxW + 1;
    localparam int unsigned OffsetW = (LineBytes > 1) ? $clog2(LineBytes) : 0;

    localparam logic [AddrWidth-1:0] LineMask = ~((AddrWidth'(1) << OffsetW) - AddrWidth'(1));
    localparam logic [CntWidth-1:0]  CntMax   = {CntWidth{1'b1}};
    localparam logic [CntWidth-1:0]  CntOne   = CntWidth'(1);

    logic [AddrWidth-1:0] entry_addr_q  [Depth];
    logic [Depth-1:0]     entry_valid_q;
    logic [PtrW-1:0]      wr_ptr_q;
    logic [PtrW-1:0]      rd_ptr_q;
    logic [CntWidth-1:0]  coalesce_cnt_q;

    logic [IdxW-1:0]      wr_idx;
    logic [IdxW-1:0]      rd_idx;
    logic                 empty;
    logic                 full;
    logic [AddrWidth-1:0] line_addr;
    logic                 in_hs;
    logic                 out_hs;
    logic                 match;
    logic                 do_coalesce;
    logic                 do_push;

    assign wr_idx = wr_ptr_q[IdxW-1:0];
    assign rd_idx = rd_ptr_q[IdxW-1:0];
    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_ptr_q[PtrW-1] != rd_ptr_q[PtrW-1]) &&
                    (wr_ptr_q[IdxW-1:0] == rd_ptr_q[IdxW-1:0]);

    assign line_addr = inval_addr_i & LineMask;

    // Ready depends only on stored occupancy, never on the CVA6 side ready.
    assign inval_ready_o = !full;
    assign in_hs         = inval_valid_i && inval_ready_o;

    assign inval_valid_o = !empty;
    assign inval_addr_o  = empty ? '0 : entry_addr_q[rd_idx];
    assign busy_o        = !empty;
    assign out_hs        = inval_valid_o && inval_ready_i;

    // Look for a queued copy of the line; the head leaving this cycle does not
    // count, since a write after an in-flight invalidation needs a fresh one.
    always_comb begin
        match = 1'b0;
        for (int i = 0; i < Depth; i++) begin
            if (entry_valid_q[i] && (entry_addr_q[i] == line_addr) &&
                !(out_hs && (rd_idx == IdxW'(i)))) begin
                match = 1'b1;
            end
        end
    end

    assign do_coalesce = in_hs && en_i && match;
    assign do_push     = in_hs && en_i && !match;

    // FIFO storage and pointer update; push and pop may both happen in one cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            entry_valid_q <= '0;
            for (int i = 0; i < Depth; i++) begin
                entry_addr_q[i] <= '0;
            end
        end else begin
            if (out_hs) begin
                entry_valid_q[rd_idx] <= 1'b0;
                rd_ptr_q              <= rd_ptr_q + PtrW'(1);
            end
            if (do_push) begin
                entry_valid_q[wr_idx] <= 1'b1;
                entry_addr_q[wr_idx]  <= line_addr;
                wr_ptr_q              <= wr_ptr_q + PtrW'(1);
            end
        end
    end

    // Saturating coalesce counter; clear wins over a same-cycle increment.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            coalesce_cnt_q <= '0;
        end else if (clr_cnt_i) begin
            coalesce_cnt_q <= '0;
        end else if (do_coalesce && (coalesce_cnt_q != CntMax)) begin
            coalesce_cnt_q <= coalesce_cnt_q + CntOne;
        end
    end

    assign coalesce_cnt_o = coalesce_cnt_q;

endmodule

// File: tb/tb_ara_inval_buffer.sv
// Directed bench for ara_inval_buffer (Depth=4, LineBytes=16, CntWidth=4).
module tb_ara_inval_buffer;

    localparam int AW = 64;
    localparam int CW = 4;

    logic          clk_i;
    logic          rst_ni;
    logic          en_i;
    logic          clr_cnt_i;
    logic [AW-1:0] inval_addr_i;
    logic          inval_valid_i;
    logic          inval_ready_o;
    logic [AW-1:0] inval_addr_o;
    logic          inval_valid_o;
    logic          inval_ready_i;
    logic          busy_o;
    logic [CW-1:0] coalesce_cnt_o;

    int n_assert = 0;
    int n_fail   = 0;

    ara_inval_buffer #(
        .Depth    (4),
        .AddrWidth(AW),
        .LineBytes(16),
        .CntWidth (CW)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .en_i          (en_i),
        .clr_cnt_i     (clr_cnt_i),
        .inval_addr_i  (inval_addr_i),
        .inval_valid_i (inval_valid_i),
        .inval_ready_o (inval_ready_o),
        .inval_addr_o  (inval_addr_o),
        .inval_valid_o (inval_valid_o),
        .inval_ready_i (inval_ready_i),
        .busy_o        (busy_o),
        .coalesce_cnt_o(coalesce_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " valid_o"}, 64'(inval_valid_o), 64'd0);
        chk({tag, " addr_o"},  inval_addr_o,       64'd0);
        chk({tag, " busy"},    64'(busy_o),        64'd0);
        chk({tag, " cnt"},     64'(coalesce_cnt_o), 64'd0);
        chk({tag, " ready_o"}, 64'(inval_ready_o), 64'd1);
    endtask

    initial begin
        rst_ni        = 1'b0;
        en_i          = 1'b1;
        clr_cnt_i     = 1'b0;
        inval_addr_i  = '0;
        inval_valid_i = 1'b0;
        inval_ready_i = 1'b0;
        #1;
        chk_reset_vals("reset");
        #12;
        rst_ni = 1'b1;
        tick();

        // Single request: one cycle latency, line aligned, one cycle valid
        inval_ready_i = 1'b1;
        inval_valid_i = 1'b1;
        inval_addr_i  = 64'h8000_1234;
        chk("single no bypass", 64'(inval_valid_o), 64'd0);
        tick();
        inval_valid_i = 1'b0;
        chk("single valid", 64'(inval_valid_o), 64'd1);
        chk("single addr", inval_addr_o, 64'h8000_1230);
        chk("single busy", 64'(busy_o), 64'd1);
        tick();
        chk("single valid after", 64'(inval_valid_o), 64'd0);
        chk("single busy after", 64'(busy_o), 64'd0);

        // Coalesce: 0x1008 merges into 0x1000's line
        inval_ready_i = 1'b0;
        inval_valid_i = 1'b1;
        inval_addr_i  = 64'h1000; tick();
        inval_addr_i  = 64'h1008; tick();
        inval_addr_i  = 64'h1010; tick();
        inval_valid_i = 1'b0;
        chk("coal cnt", 64'(coalesce_cnt_o), 64'd1);
        chk("coal head", inval_addr_o, 64'h1000);
        chk("coal stable", 64'(inval_valid_o), 64'd1);
        tick();
        chk("coal hold addr", inval_addr_o, 64'h1000);
        inval_ready_i = 1'b1;
        tick();
        chk("coal second", inval_addr_o, 64'h1010);
        tick();
        chk("coal drained", 64'(inval_valid_o), 64'd0);
        inval_ready_i = 1'b0;

        // Full and backpressure
        inval_valid_i = 1'b1;
        inval_addr_i  = 64'h00; tick();
        inval_addr_i  = 64'h10; tick();
        inval_addr_i  = 64'h20; tick();
        inval_addr_i  = 64'h30; tick();
        chk("full ready_o", 64'(inval_ready_o), 64'd0);
        // coalescible request while full is stalled, not counted
        inval_addr_i = 64'h18;
        tick();
        chk("full stall cnt", 64'(coalesce_cnt_o), 64'd1);
        inval_valid_i = 1'b0;
        inval_ready_i = 1'b1;
        chk("full no ready on pop", 64'(inval_ready_o), 64'd0);
        tick();
        inval_ready_i = 1'b0;
        chk("full ready after pop", 64'(inval_ready_o), 64'd1);
        chk("full head 0x10", inval_addr_o, 64'h10);
        inval_ready_i = 1'b1;
        tick();
        chk("full head 0x20", inval_addr_o, 64'h20);
        tick();
        chk("full head 0x30", inval_addr_o, 64'h30);
        tick();
        chk("full drained", 64'(busy_o), 64'd0);
        inval_ready_i = 1'b0;

        // Pop/match race at the head
        inval_valid_i = 1'b1;
        inval_addr_i  = 64'h40;
        tick();
        inval_addr_i  = 64'h44;
        inval_ready_i = 1'b1;
        chk("race head", inval_addr_o, 64'h40);
        tick();
        inval_valid_i = 1'b0;
        chk("race repush valid", 64'(inval_valid_o), 64'd1);
        chk("race repush addr", inval_addr_o, 64'h40);
        chk("race cnt", 64'(coalesce_cnt_o), 64'd1);
        tick();
        chk("race drained", 64'(inval_valid_o), 64'd0);
        inval_ready_i = 1'b0;

        // Disable: discard while pending entry still drains
        inval_valid_i = 1'b1;
        inval_addr_i  = 64'h300;
        tick();
        en_i         = 1'b0;
        inval_addr_i = 64'h200;
        chk("dis ready_o", 64'(inval_ready_o), 64'd1);
        tick();
        inval_addr_i = 64'h300;
        tick();
        inval_valid_i = 1'b0;
        chk("dis head", inval_addr_o, 64'h300);
        chk("dis cnt", 64'(coalesce_cnt_o), 64'd1);
        inval_ready_i = 1'b1;
        tick();
        chk("dis drained", 64'(inval_valid_o), 64'd0);
        inval_ready_i = 1'b0;
        en_i = 1'b1;

        // Counter saturation and clear
        clr_cnt_i = 1'b1;
        tick();
        clr_cnt_i = 1'b0;
        chk("clr cnt", 64'(coalesce_cnt_o), 64'd0);
        inval_valid_i = 1'b1;
        inval_addr_i  = 64'h500;
        tick();
        inval_addr_i  = 64'h504;
        for (int i = 0; i < 17; i++) tick();
        chk("sat cnt", 64'(coalesce_cnt_o), 64'hF);
        clr_cnt_i = 1'b1;
        tick();
        clr_cnt_i = 1'b0;
        chk("clr prio", 64'(coalesce_cnt_o), 64'd0);
        tick();
        chk("cnt after clr", 64'(coalesce_cnt_o), 64'd1);
        inval_addr_i = 64'h600;
        tick();
        inval_valid_i = 1'b0;
        inval_ready_i = 1'b1;
        tick();
        chk("drain head", inval_addr_o, 64'h600);
        rst_ni = 1'b0;
        #1;
        chk_reset_vals("async reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
